// File: rtl/tm_infer_seq_if.sv
// Handshake and configuration bundle for the sequential Tsetlin-machine
// inference engine: mask programming port, feature input, result output.
`timescale 1ns/1ps

interface tm_infer_seq_if #(
   parameter int N_FEAT   = 2,
   parameter int N_CLASS  = 2,
   parameter int N_CLAUSE = 4
) ();
   localparam int N_TOT = N_CLASS * N_CLAUSE;
   localparam int AW    = $clog2(N_TOT);
   localparam int CLW   = $clog2(N_CLASS);
   localparam int SW    = $clog2(N_CLAUSE + 1) + 1;
   localparam int MW    = 2 * N_FEAT;

   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [MW-1:0]        cfg_data;
   logic                 cfg_err;
   logic                 in_valid;
   logic                 in_ready;
   logic [N_FEAT-1:0]    features;
   logic                 out_valid;
   logic                 out_ready;
   logic [CLW-1:0]       final_class;
   logic signed [SW-1:0] final_score;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      input  cfg_err, in_ready, out_valid, final_class, final_score
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      output cfg_err, in_ready, out_valid, final_class, final_score
   );
endinterface

// File: rtl/tm_infer_seq.sv
// Sequential Tsetlin-machine inference: one clause evaluated per clock,
// per-class +/-1 vote accumulation, argmax with ties to the lowest class.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a feature vector; mask writes accepted
// EVAL  | walking clauses 0..N_TOT-1, one per edge; mask writes dropped
// DONE  | result held on out_valid until out_ready; mask writes dropped
`timescale 1ns/1ps

module tm_infer_seq #(
   parameter int N_FEAT   = 2,
   parameter int N_CLASS  = 2,
   parameter int N_CLAUSE = 4
) (
   input  logic          clk,
   input  logic          rst,
   tm_infer_seq_if.slave bus
);
   localparam int N_TOT = N_CLASS * N_CLAUSE;
   localparam int AW    = $clog2(N_TOT);
   localparam int CLW   = $clog2(N_CLASS);
   localparam int CIW   = $clog2(N_CLAUSE);
   localparam int SW    = $clog2(N_CLAUSE + 1) + 1;
   localparam int MW    = 2 * N_FEAT;
   localparam logic [AW:0] TOT_L = (AW+1)'(N_TOT);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [MW-1:0]        mask_q [N_TOT];
   logic [N_FEAT-1:0]    feat_q;
   logic [AW-1:0]        ptr_q;
   logic [CLW-1:0]       cls_q;
   logic [CIW-1:0]       cl_q;
   logic signed [SW-1:0] acc_q, best_score_q, final_score_q;
   logic [CLW-1:0]       best_class_q, final_class_q;
   logic                 out_valid_q, cfg_err_q;

   logic [MW-1:0]        lits, cur_mask;
   logic                 fire, last_clause, last_eval, take_best, addr_ok;
   logic signed [SW-1:0] vote, class_sum;

   // Clause evaluation and running class sum for the clause under ptr
   always_comb begin
      lits        = {~feat_q, feat_q};
      cur_mask    = mask_q[ptr_q];
      fire        = (cur_mask != '0) && ((cur_mask & ~lits) == '0);
      vote        = '0;
      if (fire) vote = cl_q[0] ? {SW{1'b1}} : SW'(1);
      class_sum   = acc_q + vote;
      last_clause = (cl_q == CIW'(N_CLAUSE - 1));
      last_eval   = last_clause && (cls_q == CLW'(N_CLASS - 1));
      // class 0 seeds the best, later classes must beat it strictly
      take_best   = (cls_q == '0) || (class_sum > best_score_q);
      addr_ok     = ({1'b0, bus.cfg_addr} < TOT_L);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid) state_d = S_EVAL;
         S_EVAL:  if (last_eval)    state_d = S_DONE;
         S_DONE:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and result outputs
   always_comb begin
      bus.in_ready    = (state_q == S_IDLE);
      bus.out_valid   = out_valid_q;
      bus.cfg_err     = cfg_err_q;
      bus.final_class = final_class_q;
      bus.final_score = final_score_q;
   end

   // Mask storage; writes only land while idle, otherwise flagged for one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_TOT; i++) mask_q[i] <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= bus.cfg_we && (state_q != S_IDLE);
         if (bus.cfg_we && (state_q == S_IDLE) && addr_ok)
            mask_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // Evaluation datapath: capture, accumulate, track best, publish result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         feat_q        <= '0;
         ptr_q         <= '0;
         cls_q         <= '0;
         cl_q          <= '0;
         acc_q         <= '0;
         best_score_q  <= '0;
         best_class_q  <= '0;
         final_score_q <= '0;
         final_class_q <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  feat_q <= bus.features;
                  ptr_q  <= '0;
                  cls_q  <= '0;
                  cl_q   <= '0;
                  acc_q  <= '0;
               end
            end
            S_EVAL: begin
               ptr_q <= ptr_q + 1'b1;
               if (last_clause) begin
                  acc_q <= '0;
                  cl_q  <= '0;
                  cls_q <= cls_q + 1'b1;
                  if (take_best) begin
                     best_score_q <= class_sum;
                     best_class_q <= cls_q;
                  end
               end else begin
                  acc_q <= class_sum;
                  cl_q  <= cl_q + 1'b1;
               end
               if (last_eval) begin
                  final_class_q <= take_best ? cls_q : best_class_q;
                  final_score_q <= take_best ? class_sum : best_score_q;
                  out_valid_q   <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) out_valid_q <= 1'b0;
            end
            default: out_valid_q <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_tm_infer_seq.sv
// Self-checking bench for tm_infer_seq: directed table, handshake corner
// cases, reset abort, and randomized runs against a clause-level model.
`timescale 1ns/1ps

module tb_tm_infer_seq;
   localparam int N_FEAT   = 2;
   localparam int N_CLASS  = 2;
   localparam int N_CLAUSE = 4;
   localparam int N_TOT    = N_CLASS * N_CLAUSE;
   localparam int MW       = 2 * N_FEAT;

   typedef struct {
      logic [N_FEAT-1:0] feat;
      int                exp_class;
      int                exp_score;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tm_infer_seq_if #(.N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .N_CLAUSE(N_CLAUSE)) bus ();

   tm_infer_seq #(.N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .N_CLAUSE(N_CLAUSE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [MW-1:0] mdl_mask [N_TOT];
   vec_t tbl [4];
   logic [MW-1:0] set_a [N_TOT];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // A clause fires when every included positive literal has its feature
   // set and every included negated literal has its feature clear.
   function automatic void model(input logic [N_FEAT-1:0] f, output int cls, output int score);
      int best;
      best = 0;
      cls  = 0;
      for (int c = 0; c < N_CLASS; c++) begin
         int sum;
         sum = 0;
         for (int k = 0; k < N_CLAUSE; k++) begin
            logic [MW-1:0] m;
            bit sat;
            m   = mdl_mask[c*N_CLAUSE + k];
            sat = (m != 0);
            for (int j = 0; j < N_FEAT; j++) begin
               if (m[j] && !f[j]) sat = 0;
               if (m[N_FEAT+j] && f[j]) sat = 0;
            end
            if (sat) sum += (k % 2 == 0) ? 1 : -1;
         end
         if (c == 0 || sum > best) begin
            best = sum;
            cls  = c;
         end
      end
      score = best;
   endfunction

   task automatic cfg_write(input int addr, input logic [MW-1:0] data);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr[2:0];
      bus.cfg_data = data;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      mdl_mask[addr] = data;
      check("cfg_err_idle", int'(bus.cfg_err), 0);
   endtask

   task automatic start(input logic [N_FEAT-1:0] f);
      bus.in_valid = 1'b1;
      bus.features = f;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("accept_in_ready", int'(bus.in_ready), 0);
   endtask

   task automatic wait_result(input string name, input int already);
      int k;
      bit seen;
      k    = already;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (bus.out_valid) seen = 1;
      end
      check({name, "_latency"}, seen ? k : -1, N_TOT);
   endtask

   task automatic consume(input string name);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, "_out_valid_clr"}, int'(bus.out_valid), 0);
      check({name, "_in_ready_idle"}, int'(bus.in_ready), 1);
   endtask

   task automatic run_vec(input string name, input logic [N_FEAT-1:0] f,
                          input int ec, input int es);
      start(f);
      check({name, "_early_valid"}, int'(bus.out_valid), 0);
      wait_result(name, 0);
      check({name, "_class"}, int'(bus.final_class), ec);
      check({name, "_score"}, $signed(bus.final_score), es);
      consume(name);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ec, es;
      bit spurious;
      logic [N_FEAT-1:0] f;

      tbl[0] = '{feat: 2'b01, exp_class: 1, exp_score:  1};
      tbl[1] = '{feat: 2'b00, exp_class: 0, exp_score:  2};
      tbl[2] = '{feat: 2'b10, exp_class: 1, exp_score:  0};
      tbl[3] = '{feat: 2'b11, exp_class: 0, exp_score:  0};
      set_a = '{4'b1100, 4'b1001, 4'b1100, 4'b0110, 4'b0101, 4'b1100, 4'b0001, 4'b0011};

      rst           = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      bus.in_valid  = 1'b0;
      bus.features  = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < N_TOT; i++) mdl_mask[i] = '0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_cfg_err", int'(bus.cfg_err), 0);
      check("rst_class", int'(bus.final_class), 0);
      check("rst_score", $signed(bus.final_score), 0);
      rst = 1'b1;
      @(negedge clk);

      run_vec("zero_masks", 2'b11, 0, 0);

      for (int i = 0; i < N_TOT; i++) cfg_write(i, set_a[i]);
      for (int i = 0; i < 4; i++)
         run_vec($sformatf("tbl%0d", i), tbl[i].feat, tbl[i].exp_class, tbl[i].exp_score);

      // backpressure in DONE, a dropped write there, and a waiting vector
      start(2'b01);
      wait_result("bp", 0);
      bus.in_valid = 1'b1;
      bus.features = 2'b00;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.cfg_we = 1'b0;
         check("bp_hold_valid", int'(bus.out_valid), 1);
         check("bp_hold_ready", int'(bus.in_ready), 0);
         check("bp_hold_class", int'(bus.final_class), 1);
         check("bp_hold_score", $signed(bus.final_score), 1);
         check("bp_cfg_err", int'(bus.cfg_err), (i == 0) ? 1 : 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_release_valid", int'(bus.out_valid), 0);
      check("bp_release_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_next_accept", int'(bus.in_ready), 0);
      wait_result("bp_next", 0);
      check("bp_next_class", int'(bus.final_class), 0);
      check("bp_next_score", $signed(bus.final_score), 2);
      consume("bp_next");

      // write attempted mid-evaluation is dropped
      start(2'b01);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd6;
      bus.cfg_data = 4'b0000;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      check("eval_cfg_err_pulse", int'(bus.cfg_err), 1);
      @(negedge clk);
      check("eval_cfg_err_clear", int'(bus.cfg_err), 0);
      wait_result("eval_cfg", 3);
      check("eval_cfg_class", int'(bus.final_class), 1);
      check("eval_cfg_score", $signed(bus.final_score), 1);
      consume("eval_cfg");

      // write and accept on the same idle edge: new mask is used
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd6;
      bus.cfg_data = 4'b0000;
      bus.in_valid = 1'b1;
      bus.features = 2'b01;
      @(negedge clk);
      bus.cfg_we   = 1'b0;
      bus.in_valid = 1'b0;
      mdl_mask[6]  = 4'b0000;
      check("same_edge_accept", int'(bus.in_ready), 0);
      wait_result("same_edge", 0);
      check("same_edge_class", int'(bus.final_class), 1);
      check("same_edge_score", $signed(bus.final_score), 0);
      consume("same_edge");
      cfg_write(6, 4'b0001);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1)
            cfg_write(int'($urandom_range(0, N_TOT-1)), MW'($urandom_range(0, 15)));
         f = N_FEAT'($urandom_range(0, 3));
         model(f, ec, es);
         run_vec($sformatf("rand%0d", it), f, ec, es);
      end

      // reset during evaluation aborts it and clears the masks
      start(2'b01);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_in_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N_TOT; i++) mdl_mask[i] = '0;
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.out_valid) spurious = 1;
      end
      check("abort_no_result", int'(spurious), 0);
      check("abort_idle_ready", int'(bus.in_ready), 1);
      run_vec("post_reset", 2'b01, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tm_infer_seq.md
Name: tm_infer_seq

Overview:
- Parametrised, sequential Tsetlin-machine inference engine, successor to the fixed 2-feature, 8-clause classifier.
- Clause include masks are runtime-programmable through a config port.
- Each accepted feature vector is evaluated one clause per cycle; the block emits the winning class and its vote score over a valid/ready handshake.
- Sits between the feature-capture stage and the downstream result consumer.

Parameters:
- N_FEAT, 2: number of boolean features; each clause mask is 2*N_FEAT bits wide.
- N_CLASS, 2: number of classes (>=2).
- N_CLAUSE, 4: clauses per class; must be even, >=2.
- Derived:
  - N_TOT = N_CLASS*N_CLAUSE.
  - AW = clog2(N_TOT).
  - CLW = clog2(N_CLASS).
  - SW = clog2(N_CLAUSE+1)+1 (signed score width).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  mask write strobe.
- cfg_addr  in  AW  clause address = class*N_CLAUSE + clause.
- cfg_data  in  2*N_FEAT  include mask.
- cfg_err  out  1  one-cycle pulse: write dropped because the engine was busy.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine idle, can accept a vector.
- features  in  N_FEAT  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- final_class  out  CLW  winning class index.
- final_score  out  SW  signed vote sum of the winning class.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All N_TOT masks, features_reg, the accumulators and final_class/final_score are cleared to 0.
  - out_valid=0, cfg_err=0.
  - A reset asserted mid-evaluation aborts it; no result is produced.
- Literal vector L, 2*N_FEAT bits:
  - L[N_FEAT-1:0] = features_reg.
  - L[2*N_FEAT-1:N_FEAT] = ~features_reg.
- Clause output: 1 iff mask != 0 and (mask & ~L) == 0. An all-zero mask always outputs 0.
- Polarity: clauses with an even clause index within a class vote +1; odd indices vote -1.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture features into features_reg, clear the accumulator, set ptr=0, go to EVAL.
  - A cfg_we in IDLE writes mask[cfg_addr] on that edge.
  - If cfg_we and in_valid occur on the same edge, both take effect; the new vector is evaluated with the updated mask.
- FSM EVAL:
  - in_ready=0.
  - Each edge evaluates clause ptr and adds ±1 to the class accumulator.
  - At the last clause of a class, compare that class's final sum against best_score. Strictly greater replaces the best. Class 0 always initialises the best, so ties go to the lowest class index.
  - ptr increments; cfg_we is dropped and cfg_err pulses on the next edge.
  - The edge that evaluates ptr=N_TOT-1 loads final_class/final_score, sets out_valid=1 and goes to DONE.
- Latency: out_valid rises exactly N_TOT rising edges after the accepting edge (8 at defaults).
- FSM DONE:
  - Outputs are held stable while out_valid&!out_ready.
  - On out_valid&out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE; there is no back-to-back overlap.
  - cfg_we is dropped with cfg_err.
- Arithmetic:
  - Accumulator range is [-N_CLAUSE/2, +N_CLAUSE/2]; it never overflows at SW bits.
  - Comparison is signed.
- Minimum throughput: one result per N_TOT+2 cycles when out_ready=1.

Test Plan:
- Program addresses 0..7 with 1100,1001,1100,0110,0101,1100,0001,0011; send features=01 -> out_valid 8 edges after accept, final_class=1, final_score=+1 (class 0 score -1).
- Same masks, features=00 -> final_class=0, final_score=+2 (class 1 score -1).
- Masks left at reset (all 0), features=11 -> all scores 0, tie, final_class=0, final_score=0.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a vector offered with in_valid=1 is not accepted; after out_ready=1, IDLE, and the next vector is accepted.
- cfg_we to addr 6 with data 0000 during EVAL -> cfg_err pulses once, mask unchanged, result identical to the first scenario.
- Assert rst low at the 4th EVAL edge -> out_valid=0, in_ready=1 after release, all masks 0; a re-run with features=01 gives class 0, score 0.
